// File: rtl/nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// nco_sweep_ctrl
//
// Control stage ahead of the NCO core. Produces the phase-increment word that
// drives the NCO phi_inc_i input, giving linear frequency sweeps from a start
// increment to a stop increment. Saw (up only) or triangle (up then down)
// sweeps are supported, either single-shot or continuous. The block shares
// clk, reset and clken with the NCO, so every sweep step lands on the same
// clock-enable grid as the phase accumulator.
//
// Parameters
//   apr        phase-increment width, equal to the NCO accumulator width
//   cw         width of the dwell counter
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   clken      clock enable; when low all state except done is frozen
//   start      sweep request, sampled when clken=1
//   abort      stop the sweep, sampled when clken=1 (no done pulse)
//   cont       continuous mode, latched at start
//   tri_mode   triangle mode (up then down), latched at start
//   f_start    lower/start increment, unsigned, latched at start
//   f_stop     upper/stop increment, unsigned, latched at start
//   f_step     increment per step (0 is treated as 1), latched at start
//   dwell      extra clken cycles each value is held, latched at start
//   phi_inc_o  registered increment to the NCO
//   busy       sweep in progress
//   done       one-clk pulse at the natural end of a non-continuous sweep
// -----------------------------------------------------------------------------
module nco_sweep_ctrl #(
  parameter int apr = 32,
  parameter int cw  = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic           start,
  input  logic           abort,
  input  logic           cont,
  input  logic           tri_mode,
  input  logic [apr-1:0] f_start,
  input  logic [apr-1:0] f_stop,
  input  logic [apr-1:0] f_step,
  input  logic [cw-1:0]  dwell,
  output logic [apr-1:0] phi_inc_o,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t          state;
  logic [cw-1:0]   cnt;

  // Shadow copies of the sweep settings, so the inputs may change while busy.
  logic            cont_q;
  logic            tri_q;
  logic [apr-1:0]  f_start_q;
  logic [apr-1:0]  f_stop_q;
  logic [apr-1:0]  step_q;
  logic [cw-1:0]   dwell_q;

  // Next values for a step up / down, computed one bit wider so that neither
  // the sum can wrap past 2^apr-1 nor the difference underflow below zero.
  logic [apr:0]    sum_w;
  logic [apr:0]    floor_w;
  logic [apr-1:0]  up_next;
  logic [apr-1:0]  dn_next;

  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path,
    // otherwise synthesis infers a latch to hold the old value.
    sum_w   = {1'b0, phi_inc_o} + {1'b0, step_q};
    up_next = (sum_w > {1'b0, f_stop_q}) ? f_stop_q : sum_w[apr-1:0];
    // Stepping down would go below f_start exactly when phi < f_start + step.
    floor_w = {1'b0, f_start_q} + {1'b0, step_q};
    dn_next = ({1'b0, phi_inc_o} < floor_w) ? f_start_q : (phi_inc_o - step_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow registers and dwell counter are reset along with the
      // control state so a mid-sweep reset leaves no stale settings behind.
      state     <= IDLE;
      cnt       <= '0;
      cont_q    <= 1'b0;
      tri_q     <= 1'b0;
      f_start_q <= '0;
      f_stop_q  <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      phi_inc_o <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      // done is cleared on every edge, clken or not, so it is one clk wide.
      done <= 1'b0;

      if (clken) begin
        if (abort) begin
          // Abort beats start: hold the current output, no done pulse.
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          unique case (state)
            IDLE: begin
              if (start) begin
                cont_q    <= cont;
                tri_q     <= tri_mode;
                f_start_q <= f_start;
                f_stop_q  <= f_stop;
                step_q    <= (f_step == '0) ? apr'(1) : f_step;
                dwell_q   <= dwell;
                phi_inc_o <= f_start;
                if (f_start >= f_stop) begin
                  // Empty range: present f_start and finish immediately.
                  done <= 1'b1;
                end else begin
                  cnt   <= dwell;
                  busy  <= 1'b1;
                  state <= UP;
                end
              end
            end

            UP: begin
              if (cnt != '0) begin
                cnt <= cnt - cw'(1);
              end else begin
                cnt <= dwell_q;
                if (phi_inc_o == f_stop_q) begin
                  if (tri_q) begin
                    // Turnaround starts the descent at once so f_stop is
                    // held only one dwell period.
                    state     <= DOWN;
                    phi_inc_o <= dn_next;
                  end else if (cont_q) begin
                    phi_inc_o <= f_start_q;
                  end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end
                end else begin
                  phi_inc_o <= up_next;
                end
              end
            end

            DOWN: begin
              if (cnt != '0) begin
                cnt <= cnt - cw'(1);
              end else begin
                cnt <= dwell_q;
                if (phi_inc_o == f_start_q) begin
                  if (cont_q) begin
                    // Same turnaround rule at the bottom of the triangle.
                    state     <= UP;
                    phi_inc_o <= up_next;
                  end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end
                end else begin
                  phi_inc_o <= dn_next;
                end
              end
            end

            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nco_sweep_ctrl
//
// Self-checking bench for nco_sweep_ctrl. A table of per-cycle control inputs
// with hand-computed expected outputs covers reset, a single saw sweep and
// abort; hand-written sequences cover clken gating, clamping, overflow,
// triangle continuous mode, degenerate inputs and a mid-sweep reset.
// -----------------------------------------------------------------------------
module tb_nco_sweep_ctrl;

  logic        clk;
  logic        reset;
  logic        clken;
  logic        start;
  logic        abort;
  logic        cont;
  logic        tri_mode;
  logic [31:0] f_start;
  logic [31:0] f_stop;
  logic [31:0] f_step;
  logic [15:0] dwell;
  logic [31:0] phi_inc_o;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  nco_sweep_ctrl #(.apr(32), .cw(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .clken     (clken),
    .start     (start),
    .abort     (abort),
    .cont      (cont),
    .tri_mode  (tri_mode),
    .f_start   (f_start),
    .f_stop    (f_stop),
    .f_step    (f_step),
    .dwell     (dwell),
    .phi_inc_o (phi_inc_o),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ce;
    logic        st;
    logic        ab;
    logic [31:0] phi;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  function automatic vec_t mk(input logic rst, input logic ce, input logic st,
                              input logic ab, input logic [31:0] phi,
                              input logic bsy, input logic dn);
    vec_t v;
    v.rst = rst; v.ce = ce; v.st = st; v.ab = ab;
    v.phi = phi; v.bsy = bsy; v.dn = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [31:0] phi,
                           input logic bsy, input logic dn);
    check({name, ".phi"},  phi_inc_o, phi);
    check({name, ".busy"}, {31'd0, busy}, {31'd0, bsy});
    check({name, ".done"}, {31'd0, done}, {31'd0, dn});
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fp,
                           input logic [31:0] fst, input logic [15:0] dw,
                           input logic c, input logic t);
    f_start = fs; f_stop = fp; f_step = fst; dwell = dw;
    cont = c; tri_mode = t; clken = 1'b1; abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Expects exp_q as the values seen after the accepting edge, then a done.
  task automatic check_seq(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      check_out($sformatf("%s[%0d]", name, i), exp_q[i], 1'b1, 1'b0);
    end
    tick();
    check_out({name, ".end"}, exp_q[exp_q.size()-1], 1'b0, 1'b1);
    tick();
    check_out({name, ".post"}, exp_q[exp_q.size()-1], 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; start = 1'b0; abort = 1'b0;
    cont = 1'b0; tri_mode = 1'b0;
    f_start = 32'd100; f_stop = 32'd130; f_step = 32'd10; dwell = 16'd1;

    // ---- Table: reset, single saw sweep 100..130 step 10 dwell 1, abort ----
    //                 rst ce  st  ab   phi  bsy dn
    vecs.push_back(mk(1, 1, 0, 0, 32'd0,   0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd0,   0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'd100, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd100, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd110, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd110, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd120, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd120, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd130, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd130, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd130, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'd130, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 32'd100, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd100, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'd110, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'd110, 0, 0));  // abort wins over start
    vecs.push_back(mk(0, 1, 0, 0, 32'd110, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 32'd110, 0, 0));  // abort blocks start in IDLE

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; clken = vecs[i].ce;
      start = vecs[i].st;  abort = vecs[i].ab;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].phi, vecs[i].bsy, vecs[i].dn);
    end
    reset = 1'b0; start = 1'b0; abort = 1'b0; clken = 1'b1;

    // ---- clken gating: same saw sweep, clken toggling 1,0,1,0 ----
    exp_q = '{32'd100, 32'd100, 32'd110, 32'd110,
              32'd120, 32'd120, 32'd130, 32'd130};
    run_sweep(32'd100, 32'd130, 32'd10, 16'd1, 1'b0, 1'b0);
    check_out("gate[0]", exp_q[0], 1'b1, 1'b0);
    for (int i = 1; i < exp_q.size(); i++) begin
      clken = 1'b0; tick();
      check_out($sformatf("gate_hold[%0d]", i), exp_q[i-1], 1'b1, 1'b0);
      clken = 1'b1; tick();
      check_out($sformatf("gate[%0d]", i), exp_q[i], 1'b1, 1'b0);
    end
    clken = 1'b0; tick();
    check_out("gate_hold_end", 32'd130, 1'b1, 1'b0);
    clken = 1'b1; tick();
    check_out("gate_done", 32'd130, 1'b0, 1'b1);
    clken = 1'b0; tick();
    check_out("gate_done_clr", 32'd130, 1'b0, 1'b0);
    clken = 1'b1;

    // ---- clamp at f_stop ----
    exp_q = '{32'd0, 32'd10, 32'd20, 32'd25};
    run_sweep(32'd0, 32'd25, 32'd10, 16'd0, 1'b0, 1'b0);
    check_seq("clamp");

    // ---- no wrap at the top of the range ----
    exp_q = '{32'hFFFF_FFF0, 32'hFFFF_FFFF};
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd0, 1'b0, 1'b0);
    check_seq("ovf");

    // ---- zero step treated as 1 ----
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3};
    run_sweep(32'd0, 32'd3, 32'd0, 16'd0, 1'b0, 1'b0);
    check_seq("step0");

    // ---- empty range: f_start == f_stop ----
    run_sweep(32'd50, 32'd50, 32'd10, 16'd0, 1'b0, 1'b0);
    check_out("degen", 32'd50, 1'b0, 1'b1);
    tick();
    check_out("degen.post", 32'd50, 1'b0, 1'b0);

    // ---- triangle continuous; a start while busy must be ignored ----
    exp_q = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0,
              32'd10, 32'd20, 32'd10, 32'd0, 32'd10};
    run_sweep(32'd0, 32'd20, 32'd10, 16'd0, 1'b1, 1'b1);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) tick();
      check_out($sformatf("tri[%0d]", i), exp_q[i], 1'b1, 1'b0);
      if (i == 3) begin
        start = 1'b1; f_start = 32'd5; f_stop = 32'd7; f_step = 32'd1;
        tri_mode = 1'b0; cont = 1'b0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    abort = 1'b1; tick();
    check_out("tri_abort", 32'd10, 1'b0, 1'b0);
    abort = 1'b0;

    // ---- synchronous reset mid-sweep ----
    run_sweep(32'd100, 32'd130, 32'd10, 16'd1, 1'b0, 1'b0);
    tick(); tick();
    check_out("pre_rst", 32'd110, 1'b1, 1'b0);
    reset = 1'b1; tick();
    check_out("mid_rst", 32'd0, 1'b0, 1'b0);
    reset = 1'b0; tick();
    check_out("post_rst", 32'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Upstream control stage for the NCO core. It generates the phase-increment word (phi_inc_o) that drives the NCO's phase-increment input, producing linear frequency sweeps from a start to a stop increment. Single or continuous sweeps are supported, either saw (up only) or triangle (up then down). It shares clk, reset and clken with the NCO, so a sweep step lands on the same clock-enable grid as the phase accumulator.

Parameters:
apr, 32, phase-increment width; must equal the NCO apr
cw, 16, width of dwell counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clken  in  1  clock enable; when low, all state except done is frozen
start  in  1  sweep request, sampled when clken=1
abort  in  1  stop sweep, sampled when clken=1
cont  in  1  continuous mode, latched at start
tri  in  1  triangle mode, latched at start
f_start  in  apr  lower/start increment, unsigned, latched at start
f_stop  in  apr  upper/stop increment, unsigned, latched at start
f_step  in  apr  increment per step, unsigned, latched at start
dwell  in  cw  extra clken cycles each value is held, latched at start
phi_inc_o  out  apr  increment to NCO phi_inc_i, registered
busy  out  1  sweep in progress
done  out  1  one-clk pulse at natural end of a non-continuous sweep

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset state:
  - phi_inc_o=0, busy=0, done=0, state=IDLE
  - shadow registers and dwell counter = 0
  - reset mid-sweep gives the same result.
- Control gating: all state advances only on clk edges with clken=1.
- done:
  - Set only on a clken=1 edge.
  - Cleared on the next clk edge regardless of clken, so it is exactly one clk wide.
- Priority when clken=1: reset > abort > start > sweep progression.
- States: IDLE, UP, DOWN.
- IDLE:
  - phi_inc_o holds its last value.
  - On start=1 with abort=0: latch cont, tri, f_start, f_stop, dwell; latch step = (f_step==0) ? 1 : f_step.
  - If f_start >= f_stop: phi_inc_o<=f_start, stay IDLE, done<=1, busy stays 0.
  - Otherwise: phi_inc_o<=f_start, cnt<=dwell, busy<=1, go to UP.
  - Latency: first value is visible 1 clk after the accepting edge.
- Dwell: each output value is held for dwell+1 clken cycles.
  - In UP/DOWN, each clken edge with cnt!=0 does cnt<=cnt-1.
  - The edge with cnt==0 is "expiry".
- UP at expiry:
  - If phi_inc_o==f_stop: end of leg.
    - tri=1: go to DOWN.
    - tri=0, cont=1: phi_inc_o<=f_start, stay UP.
    - tri=0, cont=0: go to IDLE, busy<=0, done<=1, phi_inc_o holds f_stop.
  - Else: phi_inc_o <= min(phi_inc_o+step, f_stop).
    - Sum computed in apr+1 bits, so the value never wraps past 2^apr-1.
  - At every expiry cnt<=dwell.
- DOWN at expiry:
  - If phi_inc_o==f_start: end of leg.
    - cont=1: go to UP.
    - cont=0: go to IDLE with done<=1.
  - Else: phi_inc_o <= max(phi_inc_o-step, f_start), computed in apr+1 bits with no underflow.
  - cnt<=dwell.
  - Turnaround values are not repeated: f_stop is held one dwell period, then the descent starts; likewise for f_start.
- abort=1 (clken=1):
  - Any state goes to IDLE; busy<=0; no done pulse; phi_inc_o holds its current value.
  - A start in the same cycle is ignored.
- start while busy: ignored. Input changes while busy have no effect, since the shadow registers are used.
- clken=0: phi_inc_o, cnt, state and busy are all frozen.

Test Plan:
- Reset, then single saw sweep: f_start=100, f_stop=130, f_step=10, dwell=1, cont=0, tri=0, start pulse.
  - Required: phi_inc_o = 100,100,110,110,120,120,130,130 over 8 clks (clken=1), then done=1 for 1 clk and busy 1→0.
  - phi_inc_o stays 130.
- Clamp and overflow:
  - 0/25/10, dwell=0 gives 0,10,20,25, then done.
  - 0xFFFFFFF0/0xFFFFFFFF/0x10 gives 0xFFFFFFF0, 0xFFFFFFFF, then done; the output never wraps to 0.
- Triangle continuous: 0/20/10, dwell=0, tri=1, cont=1.
  - Required: 0,10,20,10,0,10,20,… repeating; busy stays 1 and done is never asserted.
- Abort: during the first sweep, assert abort while phi_inc_o=110.
  - Required next edge: busy=0, done=0, phi_inc_o=110 held.
  - A start asserted together with abort is ignored.
- clken gating: run the saw sweep with clken toggling 1,0,1,0.
  - Sequence per clken-high cycle is identical; values are frozen across clken=0.
  - done lasts exactly 1 clk.
- Degenerate inputs:
  - f_start=50, f_stop=50 gives phi_inc_o=50, done pulse, busy never 1.
  - f_step=0 with 0/3 gives 0,1,2,3, then done.
  - Synchronous reset mid-sweep gives all outputs 0 on the next edge.
